dot_acc: RTL and testbench
==========================

# dot_acc

Downstream accumulation stage for the `dot` datapath. Consumes the 8-bit signed dot-product results `dot` emits, sums a fixed-length group of them into a 16-bit signed accumulator, then rounds, shifts and saturates the group sum back to 8 bits. The 8-bit result is presented on a valid/ready output held in a single-entry register. Used to build longer dot products (LEN × 2 terms) out of the two-term `dot` block.

## Interface
- `LEN`, default 4: samples per group; legal range 1..256.
- `SHIFT`, default 2: arithmetic right shift applied to the group sum; legal range 0..8.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous abort of the current group.
- `in_valid` in 1: `in_data` is valid; driven from the `dot` enable pipeline.
- `in_data` in 8: signed sample, typically `dot.y`.
- `in_ready` out 1: sample accepted when `in_valid && in_ready`.
- `out_valid` out 1: result register is occupied.
- `out_ready` in 1: consumer takes the result when `out_valid && out_ready`.
- `out_data` out 8: signed, saturated group result.
- `out_sat` out 1: set when `out_data` was clamped.

## Operation
- **State**
  - `cnt`: count of samples accepted in the current group, 0..LEN-1.
  - `acc`: 16-bit signed running sum.
  - Output register: `out_valid`, `out_data`, `out_sat`.
- **Reset** clears all state. `in_ready` is 1 once reset is deasserted, because it is combinational.
- **Accept, not last** (`cnt < LEN-1`):
  - `acc <= acc + sext16(in_data)`
  - `cnt <= cnt + 1`
- **Accept, last** (`cnt == LEN-1`):
  - Group sum: `s = acc + sext16(in_data)`.
  - Rounding: `r = s + (SHIFT>0 ? 1<<(SHIFT-1) : 0)`, computed in 17 bits.
  - Shift: `q = r >>> SHIFT`.
  - Saturation: if `q > 127`, `out_data` = 127. If `q < -128`, `out_data` = -128. Otherwise `out_data` = `q[7:0]`.
  - `out_sat` is 1 exactly when clamping occurred.
  - `out_valid <= 1`.
  - `acc <= 0` and `cnt <= 0`.
- With `LEN = 1`, every accepted sample is a last sample.
- **`in_ready` rule:** `in_ready = !clear && !(cnt == LEN-1 && out_valid && !out_ready)`. A non-last sample is never stalled by a full output register.
- **Output drain:** `out_valid` clears on `out_valid && out_ready`, unless a new last sample loads in the same cycle. In that case `out_valid` stays 1 and the new data replaces the old.
- **`clear`:**
  - Effect: zeroes `acc` and `cnt`.
  - Any `in_valid` sample in that cycle is not accepted, because `in_ready` is 0.
  - The output register and any output handshake proceed unaffected.
- **Accumulator width:** no overflow is possible within the legal LEN range.
- **Output stability:** `out_data` and `out_sat` must stay stable while `out_valid && !out_ready`.

## Timing
- **Latency:** result appears registered; `out_valid` rises on the clock edge that accepts the last sample of a group, i.e. one cycle after that handshake is presented.
- **Throughput:** one sample per cycle. Sustained rate is 1 result per LEN cycles with `out_ready` held high.
- **Back-to-back groups:** a last sample accepted in the same cycle the previous result drains loses no cycle.
- **Reset mid-group** discards the partial sum and any pending result, with no output handshake.
- **Output reset values:** `out_valid` = 0, `out_data` = 0, `out_sat` = 0, `in_ready` = 1 (when `clear` = 0).

## Test plan
- **Basic group** (LEN=4, SHIFT=2, `out_ready` = 1): inputs 10, 20, 30, 40 on consecutive cycles. Required: `out_valid` high for one cycle, `out_data` = 25, `out_sat` = 0.
- **Negative rounding** (LEN=4, SHIFT=2): inputs -1, -2, -3, -4, sum -10. Required: `out_data` = -2. Also, inputs -128 ×4 must give `out_data` = -128 with `out_sat` = 0.
- **Saturation** (LEN=4, SHIFT=0):
  - 127 ×4 → `out_data` = 127, `out_sat` = 1.
  - -128 ×4 → `out_data` = -128, `out_sat` = 1.
  - 1, 2, 3, 4 → `out_data` = 10, `out_sat` = 0.
- **Back-pressure** (LEN=4, SHIFT=2, `out_ready` = 0): stream 8 samples of value 4.
  - Required: first result `out_data` = 4 is held; 3 samples of the next group are accepted; `in_ready` = 0 on the 4th.
  - Then raise `out_ready` for one cycle: the 4th sample is accepted in that cycle, and `out_valid` stays 1 with `out_data` = 4 (new group).
  - No samples are lost and no result is duplicated.
- **Clear and reset:**
  - `clear` after 2 of 4 samples (values 100, 100), then 1, 1, 1, 1 → `out_data` = 1.
  - Assert `reset` asynchronously mid-group while `out_valid` = 1 → all outputs 0 immediately. The next full group then yields the correct result.
- **LEN=1, SHIFT=0, continuous stream:** inputs -5, 7, 0. Required: `out_data` follows -5, 7, 0 one cycle later each, with `out_valid` continuously 1 while `out_ready` = 1.

Source files
------------

// File: rtl/dot_acc.sv
// Group accumulator for the dot datapath: sums LEN signed samples, then
// rounds, arithmetic-shifts and saturates the sum into a single-entry output register.
module dot_acc #(
  parameter int LEN   = 4,
  parameter int SHIFT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sat
);

  // Handshakes: a transfer happens on a rising clock edge where valid && ready;
  // valid never waits on ready, and out_data/out_sat hold while out_valid && !out_ready.

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
  localparam logic [16:0]   RND      = (17'd1 << SHIFT) >> 1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [15:0] acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;

  logic               is_last;
  logic               accept;
  logic signed [15:0] sum_w;
  logic signed [16:0] rnd_w;
  logic signed [16:0] q_w;
  logic [7:0]         sat_data_w;
  logic               sat_flag_w;

  assign is_last  = (cnt_q == CNT_LAST);
  // Only the last sample of a group can be blocked by an unconsumed result.
  assign in_ready = !clear && !(is_last && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  assign sum_w = acc_q + {{8{in_data[7]}}, in_data};
  assign rnd_w = $signed({sum_w[15], sum_w}) + $signed(RND);
  assign q_w   = rnd_w >>> SHIFT;

  always_comb begin
    sat_data_w = q_w[7:0];
    sat_flag_w = 1'b0;
    if (q_w > 17'sd127) begin
      sat_data_w = 8'h7f;
      sat_flag_w = 1'b1;
    end else if (q_w < -17'sd128) begin
      sat_data_w = 8'h80;
      sat_flag_w = 1'b1;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (is_last) begin
        cnt_d       = '0;
        acc_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = sat_data_w;
        out_sat_d   = sat_flag_w;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = sum_w;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dot_acc.sv
// Bench for dot_acc: three instances (LEN/SHIFT = 4/2, 4/0, 1/0) with directed groups,
// back-pressure, clear, async reset and random traffic against a group-sum model.
module tb_dot_acc;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       clear_v, in_valid_v, out_ready_v, rand_ready;
  logic [2:0][7:0]  in_data_v;
  wire  [2:0]       in_ready_w, out_valid_w, out_sat_w;
  wire  [2:0][7:0]  out_data_w;

  int checks = 0;
  int failures = 0;

  int         gsum [3];
  int         gcnt [3];
  logic [8:0] exp_q0[$], exp_q1[$], exp_q2[$];
  logic [8:0] last_v [3];
  logic       hold_prev [3];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dot_acc #(.LEN(g == 2 ? 1 : 4), .SHIFT(g == 0 ? 2 : 0)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear_v[g]),
      .in_valid (in_valid_v[g]),
      .in_data  (in_data_v[g]),
      .in_ready (in_ready_w[g]),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready_v[g]),
      .out_data (out_data_w[g]),
      .out_sat  (out_sat_w[g])
    );
  end

  function automatic int len_of(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int shift_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Reference: round half up, floor shift, clamp to int8.
  function automatic logic [8:0] expect_of(int k, int s);
    int sh, r, q;
    sh = shift_of(k);
    r = s + ((sh > 0) ? (1 << (sh - 1)) : 0);
    q = r >>> sh;
    if (q > 127) return {1'b1, 8'h7f};
    if (q < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(q)};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int k, input logic [8:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int k, output logic [8:0] v, output bit ok);
    ok = 1'b1;
    v = '0;
    case (k)
      0: if (exp_q0.size() > 0) v = exp_q0.pop_front(); else ok = 1'b0;
      1: if (exp_q1.size() > 0) v = exp_q1.pop_front(); else ok = 1'b0;
      default: if (exp_q2.size() > 0) v = exp_q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic model_accept(input int k, input logic [7:0] d);
    gsum[k] += int'($signed(d));
    gcnt[k]++;
    if (gcnt[k] == len_of(k)) begin
      push_exp(k, expect_of(k, gsum[k]));
      gsum[k] = 0;
      gcnt[k] = 0;
    end
  endtask

  // Tasks start and end at posedge+1; acceptance is decided at the negedge before the edge.
  task automatic send(input int k, input int v);
    logic [7:0] d;
    d = 8'(v);
    in_valid_v[k] = 1'b1;
    in_data_v[k]  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (in_ready_w[k]) begin
        model_accept(k, d);
        @(posedge clock);
        #1;
        in_valid_v[k] = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout inst=%0d actual=stalled required=accepted", k);
    in_valid_v[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_clear(input int k);
    clear_v[k] = 1'b1;
    @(posedge clock);
    #1;
    clear_v[k] = 1'b0;
    gsum[k] = 0;
    gcnt[k] = 0;
  endtask

  always @(posedge clock) begin
    #1;
    for (int k = 0; k < 3; k++)
      if (rand_ready[k]) out_ready_v[k] = 1'($urandom_range(0, 1));
  end

  // Monitor: pops one expected result per output handshake; checks hold stability.
  always @(negedge clock) begin
    logic [8:0] e;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        hold_prev[k] = 1'b0;
      end else begin
        if (out_valid_w[k]) begin
          if (hold_prev[k])
            check("hold_stable", int'({out_sat_w[k], out_data_w[k]}), int'(last_v[k]));
          if (out_ready_v[k]) begin
            pop_exp(k, e, ok);
            if (!ok) begin
              checks++;
              failures++;
              $display("FAIL unexpected_result inst=%0d actual=%0d required=none", k,
                       int'($signed(out_data_w[k])));
            end else begin
              check("result_data", int'($signed(out_data_w[k])), int'($signed(e[7:0])));
              check("result_sat", int'(out_sat_w[k]), int'(e[8]));
            end
          end
        end
        hold_prev[k] = out_valid_w[k] && !out_ready_v[k];
        last_v[k]    = {out_sat_w[k], out_data_w[k]};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    reset       = 1'b1;
    clear_v     = '0;
    in_valid_v  = '0;
    in_data_v   = '0;
    out_ready_v = 3'b111;
    rand_ready  = '0;
    for (int k = 0; k < 3; k++) begin
      gsum[k] = 0;
      gcnt[k] = 0;
      hold_prev[k] = 1'b0;
      last_v[k] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_out_valid", int'(out_valid_w[k]), 0);
      check("reset_out_data", int'(out_data_w[k]), 0);
      check("reset_out_sat", int'(out_sat_w[k]), 0);
      check("reset_in_ready", int'(in_ready_w[k]), 1);
    end
    idle(1);

    // Basic group: result valid for exactly one cycle.
    send(0, 10); send(0, 20); send(0, 30); send(0, 40);
    check("basic_valid", int'(out_valid_w[0]), 1);
    check("basic_data", int'($signed(out_data_w[0])), 25);
    idle(1);
    check("basic_one_cycle", int'(out_valid_w[0]), 0);

    send(0, -1); send(0, -2); send(0, -3); send(0, -4);
    repeat (4) send(0, -128);
    idle(2);

    // Clear after two samples discards them.
    send(0, 100); send(0, 100);
    do_clear(0);
    repeat (4) send(0, 1);
    idle(2);

    // Back-pressure: second group's last sample waits for the drain.
    out_ready_v[0] = 1'b0;
    repeat (4) send(0, 4);
    repeat (3) send(0, 4);
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = 8'd4;
    @(negedge clock);
    check("bp_stall_in_ready", int'(in_ready_w[0]), 0);
    check("bp_held_valid", int'(out_valid_w[0]), 1);
    check("bp_held_data", int'($signed(out_data_w[0])), 4);
    @(posedge clock);
    #1;
    out_ready_v[0] = 1'b1;
    @(negedge clock);
    check("bp_accept_in_ready", int'(in_ready_w[0]), 1);
    if (in_ready_w[0]) model_accept(0, 8'd4);
    @(posedge clock);
    #1;
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b0;
    check("bp_reload_valid", int'(out_valid_w[0]), 1);
    check("bp_reload_data", int'($signed(out_data_w[0])), 4);
    idle(2);
    out_ready_v[0] = 1'b1;
    idle(1);
    check("bp_drained", int'(out_valid_w[0]), 0);
    check("bp_no_leftover", exp_q0.size(), 0);

    // Saturation with SHIFT=0.
    repeat (4) send(1, 127);
    repeat (4) send(1, -128);
    send(1, 1); send(1, 2); send(1, 3); send(1, 4);
    idle(2);

    // LEN=1: every sample is a result, output stays valid while streaming.
    send(2, -5);
    check("len1_valid_a", int'(out_valid_w[2]), 1);
    check("len1_data_a", int'($signed(out_data_w[2])), -5);
    send(2, 7);
    check("len1_valid_b", int'(out_valid_w[2]), 1);
    check("len1_data_b", int'($signed(out_data_w[2])), 7);
    send(2, 0);
    check("len1_valid_c", int'(out_valid_w[2]), 1);
    check("len1_data_c", int'($signed(out_data_w[2])), 0);
    idle(2);

    // Async reset mid-group with a pending result.
    out_ready_v[0] = 1'b0;
    repeat (4) send(0, 5);
    send(0, 3); send(0, 3);
    #3;
    reset = 1'b1;
    #1;
    check("areset_out_valid", int'(out_valid_w[0]), 0);
    check("areset_out_data", int'(out_data_w[0]), 0);
    check("areset_out_sat", int'(out_sat_w[0]), 0);
    for (int k = 0; k < 3; k++) begin
      gsum[k] = 0;
      gcnt[k] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready_v[0] = 1'b1;
    repeat (4) send(0, 8);
    check("post_reset_valid", int'(out_valid_w[0]), 1);
    check("post_reset_data", int'($signed(out_data_w[0])), 8);
    idle(2);

    // Random traffic with random consumer stalls and occasional clears.
    for (int k = 0; k < 3; k++) begin
      rand_ready[k] = 1'b1;
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 15) == 0) do_clear(k);
        else if ($urandom_range(0, 3) == 0) idle(1);
        case ($urandom_range(0, 5))
          0: d = 8'h7f;
          1: d = 8'h80;
          default: d = 8'($urandom_range(0, 255));
        endcase
        send(k, int'($signed(d)));
      end
      rand_ready[k] = 1'b0;
      @(posedge clock);
      #2;
      out_ready_v[k] = 1'b1;
      idle(4);
    end

    check("final_queue0", exp_q0.size(), 0);
    check("final_queue1", exp_q1.size(), 0);
    check("final_queue2", exp_q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
